// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, 32-entry register file, A/B/ALUOut and ALU.
// Driven cycle by cycle by the controller's control word; returns op/funct/zero to it.
module mc_datapath #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] readdata,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);
  localparam int NREG = 1 << REGBITS;

  logic [WIDTH-1:0]   pc_reg, instr_reg, data_reg, a_reg, b_reg, aluout_reg;
  logic [WIDTH-1:0]   pc_next, alu_result, srca, srcb, signimm, rd1, rd2, wd;
  logic [REGBITS-1:0] ra1, ra2, wa;
  logic [WIDTH-1:0]   rf_q [NREG];

  assign ra1     = instr_reg[25:21];
  assign ra2     = instr_reg[20:16];
  assign wa      = regdst ? instr_reg[15:11] : instr_reg[20:16];
  assign wd      = memtoreg ? data_reg : aluout_reg;
  assign rd1     = rf_q[ra1];
  assign rd2     = rf_q[ra2];
  assign signimm = {{16{instr_reg[15]}}, instr_reg[15:0]};

  // Register 0 is a hard zero; every other entry is an enabled flop word.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf_q[gi] = '0;
      end else begin : g_word
        logic [WIDTH-1:0] q_reg;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            q_reg <= '0;
          end else if (regwrite && (wa == REGBITS'(gi))) begin
            q_reg <= wd;
          end
        end
        assign rf_q[gi] = q_reg;
      end
    end
  endgenerate

  assign srca = alusrca ? a_reg : pc_reg;

  always_comb begin
    srcb = b_reg;
    case (alusrcb)
      2'b00:   srcb = b_reg;
      2'b01:   srcb = WIDTH'(4);
      2'b10:   srcb = signimm;
      default: srcb = signimm << 2;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alucontrol)
      3'b010:  alu_result = srca + srcb;
      3'b110:  alu_result = srca - srcb;
      3'b000:  alu_result = srca & srcb;
      3'b001:  alu_result = srca | srcb;
      3'b100:  alu_result = srca & ~srcb;
      3'b101:  alu_result = srca | ~srcb;
      3'b111:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    case (pcsrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = aluout_reg;
      2'b10:   pc_next = {pc_reg[WIDTH-1:WIDTH-4], instr_reg[25:0], 2'b00};
      default: pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg     <= '0;
      instr_reg  <= '0;
      data_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
    end else begin
      if (pcen)    pc_reg    <= pc_next;
      if (irwrite) instr_reg <= readdata;
      data_reg   <= readdata;
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout_reg <= alu_result;
    end
  end

  assign zero      = (alu_result == '0);
  assign adr       = iord ? aluout_reg : pc_reg;
  assign op        = instr_reg[31:26];
  assign funct     = instr_reg[5:0];
  assign writedata = b_reg;
endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed instruction sequences plus
// random control words checked against a cycle-level behavioural model.
module tb_mc_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pcen = 0, irwrite = 0, regwrite = 0, alusrca = 0, iord = 0, memtoreg = 0, regdst = 0;
  logic [1:0]  alusrcb = 0, pcsrc = 0;
  logic [2:0]  alucontrol = 0;
  logic [31:0] readdata = 0;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc = 0, m_instr = 0, m_data = 0, m_a = 0, m_b = 0, m_aluout = 0;
  logic [31:0] m_rf [32];

  mc_datapath #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
    .op(op), .funct(funct), .zero(zero), .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired (got=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b100:  return x & ~y;
      3'b101:  return x | ~y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] sx, sy, imm;
    imm = {{16{m_instr[15]}}, m_instr[15:0]};
    sx  = alusrca ? m_a : m_pc;
    case (alusrcb)
      2'b00:   sy = m_b;
      2'b01:   sy = 32'd4;
      2'b10:   sy = imm;
      default: sy = imm << 2;
    endcase
    return ref_alu(alucontrol, sx, sy);
  endfunction

  task automatic model_clear();
    m_pc = 0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  // One clock edge; the model advances using the inputs present before the edge.
  task automatic tick();
    logic [31:0] r, npc, v1, v2;
    logic [4:0]  wa;
    r = ref_result();
    case (pcsrc)
      2'b00:   npc = r;
      2'b01:   npc = m_aluout;
      2'b10:   npc = {m_pc[31:28], m_instr[25:0], 2'b00};
      default: npc = m_pc;
    endcase
    v1 = m_rf[m_instr[25:21]];
    v2 = m_rf[m_instr[20:16]];
    wa = regdst ? m_instr[15:11] : m_instr[20:16];
    @(posedge clk);
    if (regwrite && wa != 5'd0) m_rf[wa] = memtoreg ? m_data : m_aluout;
    if (pcen) m_pc = npc;
    if (irwrite) m_instr = readdata;
    m_data = readdata; m_a = v1; m_b = v2; m_aluout = r;
    #1;
  endtask

  task automatic ctrl(input logic pe, input logic iw, input logic rw, input logic sa, input logic io,
                      input logic mr, input logic rd, input logic [1:0] sb, input logic [1:0] ps,
                      input logic [2:0] ac);
    pcen = pe; irwrite = iw; regwrite = rw; alusrca = sa; iord = io;
    memtoreg = mr; regdst = rd; alusrcb = sb; pcsrc = ps; alucontrol = ac;
  endtask

  task automatic do_fetch(input logic [31:0] w);
    ctrl(1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
    readdata = w;
    tick();
    readdata = 0;
    $display("fetch instr=%h pc_now=%h", w, adr);
  endtask

  task automatic do_decode();
    ctrl(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
    tick();
  endtask

  task automatic do_jump();
    ctrl(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000);
    tick();
    $display("jump pc_now=%h", adr);
  endtask

  // Full lw sequence: fetch, decode, address, memory read, writeback.
  task automatic do_lw(input logic [31:0] w, input logic [31:0] value);
    do_fetch(w);
    do_decode();
    ctrl(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010); tick();
    ctrl(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010); readdata = value; tick();
    readdata = 0;
    ctrl(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010); tick();
    $display("lw instr=%h value=%h", w, value);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_fetch(32'h20080005);
    do_decode();
    ctrl(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010); tick();
    ctrl(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010); tick();
    ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000); tick();
    n_cmp++; if (writedata !== 32'd5) begin n_fail++; $display("FAIL reset_pre_rf8 got=%h exp=%h", writedata, 32'd5); end
    reset = 1'b0;
    #1;
    model_clear();
    $display("reset asserted mid-run adr=%h op=%h funct=%h", adr, op, funct);
    n_cmp++; if (adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr got=%h exp=%h", adr, 32'h0); end
    n_cmp++; if (op !== 6'h0) begin n_fail++; $display("FAIL reset_op got=%h exp=%h", op, 6'h0); end
    n_cmp++; if (funct !== 6'h0) begin n_fail++; $display("FAIL reset_funct got=%h exp=%h", funct, 6'h0); end
    n_cmp++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata got=%h exp=%h", writedata, 32'h0); end
    @(posedge clk); #1;
    reset = 1'b1;
    do_fetch(32'h20080005);
    do_decode();
    n_cmp++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_rf8 got=%h exp=%h", writedata, 32'h0); end
  endtask

  task automatic test_fetch_lw();
    apply_reset();
    do_fetch(32'h8C0A0004);
    n_cmp++; if (adr !== 32'h4) begin n_fail++; $display("FAIL fetch_pc got=%h exp=%h", adr, 32'h4); end
    n_cmp++; if (op !== 6'b100011) begin n_fail++; $display("FAIL fetch_op got=%b exp=%b", op, 6'b100011); end
    do_decode();
    ctrl(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010); tick();
    ctrl(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010);
    #1;
    n_cmp++; if (adr !== 32'h4) begin n_fail++; $display("FAIL lw_adr got=%h exp=%h", adr, 32'h4); end
    readdata = 32'h1234; tick(); readdata = 0;
    ctrl(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010); tick();
    ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000); tick();
    $display("lw $10 done writedata=%h", writedata);
    n_cmp++; if (writedata !== 32'h00001234) begin n_fail++; $display("FAIL lw_rf10 got=%h exp=%h", writedata, 32'h1234); end
  endtask

  task automatic test_slt();
    do_lw(32'h8C010000, 32'hFFFFFFFF);
    do_lw(32'h8C020000, 32'h00000001);
    do_fetch(32'h0022182A);
    n_cmp++; if (funct !== 6'b101010) begin n_fail++; $display("FAIL slt_funct got=%b exp=%b", funct, 6'b101010); end
    do_decode();
    ctrl(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b111);
    #1;
    n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL slt_zero got=%b exp=%b", zero, 1'b0); end
    tick();
    ctrl(0, 0, 1, 0, 1, 0, 1, 2'b00, 2'b00, 3'b000);
    #1;
    n_cmp++; if (adr !== 32'd1) begin n_fail++; $display("FAIL slt_aluout got=%h exp=%h", adr, 32'd1); end
    tick();
    do_fetch(32'h00031020);
    do_decode();
    $display("slt $3 done rf3=%h", writedata);
    n_cmp++; if (writedata !== 32'd1) begin n_fail++; $display("FAIL slt_rf3 got=%h exp=%h", writedata, 32'd1); end
  endtask

  task automatic test_beq();
    do_lw(32'h8C010000, 32'd7);
    do_lw(32'h8C020000, 32'd7);
    do_fetch(32'h08000003);
    do_jump();
    n_cmp++; if (adr !== 32'h0C) begin n_fail++; $display("FAIL beq_setup_pc got=%h exp=%h", adr, 32'h0C); end
    do_fetch(32'h1022FFFF);
    n_cmp++; if (adr !== 32'h10) begin n_fail++; $display("FAIL beq_fetch_pc got=%h exp=%h", adr, 32'h10); end
    do_decode();
    ctrl(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b01, 3'b110);
    #1;
    n_cmp++; if (adr !== 32'h0C) begin n_fail++; $display("FAIL beq_target got=%h exp=%h", adr, 32'h0C); end
    n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL beq_zero got=%b exp=%b", zero, 1'b1); end
    pcen = 1'b1;
    tick();
    ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
    #1;
    $display("beq taken pc=%h", adr);
    n_cmp++; if (adr !== 32'h0C) begin n_fail++; $display("FAIL beq_pc got=%h exp=%h", adr, 32'h0C); end
    // Not-taken case: $1=7 vs $3=1
    do_fetch(32'h1023FFFF);
    do_decode();
    ctrl(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110);
    #1;
    n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL bne_zero got=%b exp=%b", zero, 1'b0); end
    tick();
  endtask

  task automatic test_jump_r0();
    do_fetch(32'h08000040);
    do_jump();
    n_cmp++; if (adr !== 32'h100) begin n_fail++; $display("FAIL jump_pc got=%h exp=%h", adr, 32'h100); end
    do_lw(32'h8C000000, 32'h55);
    ctrl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000); tick();
    $display("r0 write attempt rf0=%h", writedata);
    n_cmp++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL r0_hold got=%h exp=%h", writedata, 32'h0); end
  endtask

  task automatic test_random();
    logic [31:0] exp_adr;
    logic        exp_zero;
    for (int c = 0; c < 200; c++) begin
      ctrl($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      readdata = (c % 4 == 0) ? 32'h0 : $urandom;
      #1;
      exp_adr  = iord ? m_aluout : m_pc;
      exp_zero = (ref_result() == 32'h0);
      $display("rand cyc=%0d ctl=%b%b%b rd=%h adr=%h op=%h zero=%b", c, pcen, irwrite, regwrite, readdata, adr, op, zero);
      n_cmp++; if (adr !== exp_adr) begin n_fail++; $display("FAIL rand_adr cyc=%0d got=%h exp=%h", c, adr, exp_adr); end
      n_cmp++; if (zero !== exp_zero) begin n_fail++; $display("FAIL rand_zero cyc=%0d got=%b exp=%b", c, zero, exp_zero); end
      n_cmp++; if (op !== m_instr[31:26] || funct !== m_instr[5:0]) begin
        n_fail++; $display("FAIL rand_opfunct cyc=%0d got=%h/%h exp=%h/%h", c, op, funct, m_instr[31:26], m_instr[5:0]);
      end
      n_cmp++; if (writedata !== m_b) begin n_fail++; $display("FAIL rand_writedata cyc=%0d got=%h exp=%h", c, writedata, m_b); end
      tick();
    end
  endtask

  initial begin
    model_clear();
    #12;
    reset = 1'b1;
    test_reset();
    test_fetch_lw();
    test_slt();
    test_beq();
    test_jump_r0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
